// File: rtl/commutator_alloc.sv
// Channel allocator for the 8-input / 3-output commutator: round-robin grants,
// held until released, driving the packed per-channel mux select bus.
module commutator_alloc #(
  parameter int N_REQ = 8,
  parameter int N_CH  = 3,
  parameter int SEL_W = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            req,
  input  logic [N_REQ-1:0]            rel,
  output logic [N_CH-1:0][SEL_W-1:0]  control,
  output logic [N_CH-1:0]             ch_valid,
  output logic [N_REQ-1:0]            grant,
  output logic                        full
);

  localparam int TGT_W = $clog2(N_CH);

  logic [N_CH-1:0][SEL_W-1:0] r_owner;
  logic [N_CH-1:0]            r_valid;
  logic [N_REQ-1:0]           r_grant;
  logic                       r_full;
  logic [SEL_W-1:0]           r_rr_ptr;

  logic [N_REQ-1:0]           w_elig;
  logic [N_REQ-1:0]           w_rel_eff;
  logic [SEL_W-1:0]           w_idx;
  logic [SEL_W-1:0]           w_winner;
  logic                       w_found;
  logic [TGT_W-1:0]           w_target;
  logic                       w_has_free;
  logic                       w_alloc;
  logic [N_CH-1:0][SEL_W-1:0] w_owner_nxt;
  logic [N_CH-1:0]            w_valid_nxt;
  logic [N_REQ-1:0]           w_grant_nxt;

  // A requester releasing this cycle is never eligible, so it cannot be
  // regranted until it has been seen idle for a full cycle.
  assign w_elig    = req & ~r_grant & ~rel;
  assign w_rel_eff = rel & r_grant;

  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_idx = r_rr_ptr + SEL_W'(k);
      if (!w_found && w_elig[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
  end

  // Only channels free at the start of the cycle are candidates; a channel
  // released this cycle becomes allocatable on the next one.
  always_comb begin
    w_has_free = 1'b0;
    w_target   = '0;
    for (int c = N_CH - 1; c >= 0; c--) begin
      if (!r_valid[c]) begin
        w_has_free = 1'b1;
        w_target   = TGT_W'(c);
      end
    end
  end

  assign w_alloc = w_found && w_has_free;

  always_comb begin
    w_valid_nxt = r_valid;
    w_owner_nxt = r_owner;
    w_grant_nxt = r_grant & ~w_rel_eff;
    for (int c = 0; c < N_CH; c++) begin
      if (r_valid[c] && w_rel_eff[r_owner[c]]) begin
        w_valid_nxt[c] = 1'b0;
        w_owner_nxt[c] = '0;
      end
    end
    if (w_alloc) begin
      w_valid_nxt[w_target] = 1'b1;
      w_owner_nxt[w_target] = w_winner;
      w_grant_nxt[w_winner] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner  <= '0;
      r_valid  <= '0;
      r_grant  <= '0;
      r_full   <= 1'b0;
      r_rr_ptr <= '0;
    end else begin
      r_owner <= w_owner_nxt;
      r_valid <= w_valid_nxt;
      r_grant <= w_grant_nxt;
      r_full  <= &w_valid_nxt;
      if (w_alloc) begin
        r_rr_ptr <= w_winner + SEL_W'(1);
      end
    end
  end

  assign control  = r_owner;
  assign ch_valid = r_valid;
  assign grant    = r_grant;
  assign full     = r_full;

endmodule

// File: doc/commutator_alloc.md
Name: commutator_alloc

Overview:
- Channel allocator and configurator for the 8-input, 3-output commutator datapath.
- Eight requesters compete for three output channels.
- The block grants channels round-robin and holds each grant until the owner releases it.
- It drives the packed per-channel 3-bit select bus straight into the multiplexer bank and tells downstream logic which channels carry live data.

Parameters:
- N_REQ, 8, number of requesters / datapath inputs. Fixed at 8 because the select is 3 bits wide.
- N_CH, 3, number of output channels.
- SEL_W, 3, select width per channel. Equals log2(N_REQ).

Ports:
- clk  input  1  single clock. All logic is on the rising edge.
- rst  input  1  synchronous reset, active-high.
- req  input  8  req[i] high = requester i wants a channel. Level signal, held until granted.
- rel  input  8  rel[i] high for one or more cycles = requester i releases its channel.
- control  output  [2:0][2:0]  control[c] = index of the input routed to channel c. Registered.
- ch_valid  output  3  ch_valid[c] high = channel c allocated.
- grant  output  8  grant[i] high = requester i currently owns a channel. Registered, one-hot per owner.
- full  output  1  high when all three channels are allocated.

Behaviour:
- Reset, sampled on a clk edge with rst=1:
  - control = all 0, ch_valid = 000, grant = 0, full = 0.
  - Round-robin pointer rr_ptr = 0.
  - rst overrides every other input.
  - Reset mid-operation drops all grants in that same edge.
- State per channel c:
  - FREE or BUSY (ch_valid[c]), plus owner[c] (3 bits). control[c] = owner[c].
  - In FREE, control[c] = 0.
- Eligible set, evaluated each cycle from registered state plus current inputs: E = req & ~grant & ~rel.
- Allocation, at most one per cycle:
  - Condition: E != 0 and at least one channel is FREE at the start of the cycle.
  - Winner = first set bit of E searching from rr_ptr upward, mod 8.
  - Target channel = lowest-index FREE channel.
  - On the edge: ch_valid[target]=1, control[target]=winner, grant[winner]=1, rr_ptr = (winner+1) mod 8.
- Latency: req rising before edge N gives grant/control/ch_valid updated after edge N, i.e. visible in cycle N+1.
- Release:
  - rel[i] with grant[i]=1 frees the channel whose owner == i on the next edge.
  - That channel's ch_valid goes to 0, control goes to 0, grant[i] goes to 0.
  - Any number of releases may occur in one cycle.
  - rel[i] with grant[i]=0 is ignored.
- Simultaneous events:
  - A channel freed this cycle is not available to allocation this cycle; it is allocatable from the next cycle.
  - Release and new allocation in the same cycle are both performed.
  - A requester with rel and req both high is not eligible; it is regranted no earlier than 2 cycles later.
  - req on an already-granted requester is ignored: no second channel.
- Full:
  - full = &ch_valid, registered with the state.
  - When full, no allocation occurs and rr_ptr holds.
- Empty: with E = 0, all outputs hold and rr_ptr holds.
- Invariants (required):
  - popcount(grant) == popcount(ch_valid).
  - No two valid channels share an owner.
  - control of a valid channel always points at a granted requester.

Test Plan:
1. Reset plus single request:
   - Stimulus: rst for 2 cycles, then req=00000100.
   - Required response: one cycle later grant=00000100, ch_valid=001, control[0]=2. With rst held, all outputs are 0.
2. Round-robin fill:
   - Stimulus: req=11111111 from reset.
   - Required response: successive cycles grant owners 0, 1, 2 on channels 0, 1, 2. Then full=1 and no further grants while req stays high.
3. Release and refill:
   - Stimulus: from test 2, rel=00000010 for 1 cycle.
   - Required response: next cycle ch_valid=101, control[1]=0, grant=00000101.
   - The following cycle channel 1 goes to requester 3 (rr_ptr=3), control[1]=3, full=1.
4. Simultaneous release/request:
   - Stimulus: full, rel=00000001 and req[0]=1 in the same cycle.
   - Required response: channel 0 freed. Requester 0 is not regranted in that cycle or the next. Channel 0 is given to the next eligible requester after rr_ptr.
5. Bogus inputs:
   - Stimulus: rel=10000000 with grant[7]=0; req on an owner.
   - Required response: no state change, and the invariants hold.
6. Reset mid-operation:
   - Stimulus: assert rst while 2 channels are busy and rel is active.
   - Required response: next cycle control=0, ch_valid=000, grant=0, full=0. The first grant after reset goes to the lowest requesting index.
